fir_sample_fifo: RTL and testbench
==================================

# fir_sample_fifo

Circular sample buffer that sits between the FIR input stage and the datapath. It is the responder to the `FIFO_write`/`FIFO_read` strobes issued by the FIR control unit. Each accepted write stores one input sample; each accepted read presents the oldest sample on a registered output for the multiplier/delay muxes. Status flags (`full`, `empty`, `count`) and error pulses (`overflow`, `underflow`) are returned to the control side.

## Interface
Parameters:
- `DATA_WIDTH`, 16, sample width in bits.
- `DEPTH`, 8, number of storage entries; must be a power of two and at least 2.
- `ADDR_WIDTH`, 3, log2(`DEPTH`); pointer width.

Ports:
- `CLK`  in  1  system clock; all state changes on rising edge.
- `RST`  in  1  reset. Asynchronous, active-low.
- `FIFO_write`  in  1  write strobe from the control unit; one sample per cycle while high.
- `FIFO_read`  in  1  read strobe from the control unit; one sample per cycle while high.
- `din`  in  DATA_WIDTH  sample to store; sampled on the edge where the write is accepted.
- `dout`  out  DATA_WIDTH  registered oldest-sample output; holds its value between reads.
- `valid_out`  out  1  high for exactly the cycle after an accepted read; `dout` is new in that cycle.
- `full`  out  1  high when `count` == `DEPTH`.
- `empty`  out  1  high when `count` == 0.
- `count`  out  ADDR_WIDTH+1  number of stored samples, 0..`DEPTH`.
- `overflow`  out  1  one-cycle pulse for a rejected write.
- `underflow`  out  1  one-cycle pulse for a rejected read.

## Operation
- Storage is a `DEPTH`-entry array with a write pointer `wr_ptr` and a read pointer `rd_ptr`, both `ADDR_WIDTH` bits wide. Both pointers wrap modulo `DEPTH` (for example 7 -> 0).
- Read accept: `rd_ok = FIFO_read & ~empty`. Both terms are evaluated on pre-edge state.
- Write accept: `wr_ok = FIFO_write & (~full | rd_ok)`. A write to a full buffer succeeds when a read is accepted in the same cycle.
- On `wr_ok`: `mem[wr_ptr] <= din` and `wr_ptr` increments.
- On `rd_ok`: `dout <= mem[rd_ptr]`, `rd_ptr` increments, and `valid_out <= 1`.
- When `rd_ok` is low: `valid_out <= 0` and `dout` holds its value.
- Count update:
  - `count` increments on `wr_ok & ~rd_ok`.
  - `count` decrements on `rd_ok & ~wr_ok`.
  - `count` is unchanged when both or neither are accepted.
- `full` and `empty` are registered and updated together with `count`, so they are never stale relative to `count`.
- Error pulses:
  - `overflow <= FIFO_write & ~wr_ok`
  - `underflow <= FIFO_read & ~rd_ok`
  - A rejected operation changes no pointer, no data and no count.
- There is no fall-through. With the buffer empty, a simultaneous read and write gives: write accepted, read rejected, `underflow` pulse, `count` goes to 1.
- Reset (asynchronous assertion, `RST` = 0) sets:
  - `wr_ptr` = 0, `rd_ptr` = 0, `count` = 0
  - `empty` = 1, `full` = 0
  - `dout` = 0, `valid_out` = 0, `overflow` = 0, `underflow` = 0
- Memory contents are not reset. A reset in the middle of operation discards all stored samples.
- Outputs take their reset values immediately on assertion, without waiting for a clock edge.
- After `RST` rises, the first edge that processes strobes is the first rising `CLK`.

## Timing
- Write latency: a sample written at edge N sets `empty` = 0 after edge N. It is readable by a strobe sampled at edge N+1.
- Read latency: 1 cycle. A read accepted at edge N gives `dout`/`valid_out` valid from edge N until edge N+1.
- Throughput: one write and one read per cycle, sustained, at any occupancy from 1 to `DEPTH`.
- Flags, `count` and error pulses all update on the same edge as the operation that causes them. There are no combinational paths from the strobes to any output.

## Test plan
- Reset values: hold `RST` = 0 for 2 cycles with strobes toggling. Required: `empty` = 1, `full` = 0, `count` = 0, `dout` = 0, `valid_out` = 0, no pulses.
- Fill and overflow: write 1..8 on consecutive cycles. Required: `count` steps 1..8 and `full` = 1 after the 8th write. A 9th write (value 9) gives `overflow` = 1 for one cycle and `count` stays 8.
- Drain in order and underflow: read 8 times. Required: `dout` = 1..8 in order with `valid_out` = 1 on each cycle, and `empty` = 1 after the last read. A 9th read gives `underflow` = 1 for one cycle, `valid_out` = 0 and `dout` holds 8.
- Simultaneous read/write:
  - Full with write 9 plus read: `dout` = 1, `count` stays 8, and a later drain yields 2..9.
  - Empty with write plus read: `underflow` pulse and `count` = 1.
- Wrap-around: perform 20 streaming write/read pairs at occupancy 3. Required: output order equals input order across the 7 -> 0 pointer wrap, with no flag glitches.
- Reset mid-operation: with 5 entries stored, assert `RST` between clock edges. Required: `count` = 0, `empty` = 1 and `dout` = 0 before the next clock edge. After `RST` is released, writing 0xAAAA then reading returns 0xAAAA.

Source files
------------

// File: rtl/fir_sample_fifo.sv
// Circular sample buffer answering FIFO_write/FIFO_read from the FIR control unit; dout is registered (1-cycle read latency).
// No backpressure: rejected writes/reads are dropped and flagged by one-cycle overflow/underflow pulses; write into full succeeds with a same-cycle read.
module fir_sample_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FIFO_write,
  input  logic                  FIFO_read,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_ok;
  logic                  wr_ok;
  logic [ADDR_WIDTH:0]   count_nxt;

  // Accept decisions use registered flags only, so no strobe reaches an output combinationally.
  always_comb begin
    rd_ok     = FIFO_read & ~empty;
    wr_ok     = FIFO_write & (~full | rd_ok);
    count_nxt = count;
    if (wr_ok & ~rd_ok)
      count_nxt = count + 1'b1;
    else if (rd_ok & ~wr_ok)
      count_nxt = count - 1'b1;
  end

  // Storage is deliberately not reset; pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (wr_ok)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      dout      <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      valid_out <= rd_ok;
      count     <= count_nxt;
      empty     <= (count_nxt == '0);
      full      <= (count_nxt == FULL_CNT);
      overflow  <= FIFO_write & ~wr_ok;
      underflow <= FIFO_read & ~rd_ok;
    end
  end

endmodule

// File: tb/tb_fir_sample_fifo.sv
// Directed bench for fir_sample_fifo: fill/overflow, drain/underflow, simultaneous ops, wrap, async reset.
module tb_fir_sample_fifo;

  logic        CLK = 1'b0;
  logic        RST;
  logic        FIFO_write;
  logic        FIFO_read;
  logic [15:0] din;
  logic [15:0] dout;
  logic        valid_out;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;

  int errors = 0;
  int checks = 0;

  fir_sample_fifo #(.DATA_WIDTH(16), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .CLK(CLK), .RST(RST), .FIFO_write(FIFO_write), .FIFO_read(FIFO_read),
    .din(din), .dout(dout), .valid_out(valid_out), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b0; FIFO_write = 1'b1; FIFO_read = 1'b0; din = 16'h1234;
    tick();
    FIFO_write = 1'b0; FIFO_read = 1'b1;
    tick();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_dout", dout, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    RST = 1'b1; FIFO_write = 1'b0; FIFO_read = 1'b0;
    tick();
    chk("idle_empty", empty, 1);

    // Fill 1..8
    for (int i = 1; i <= 8; i++) begin
      FIFO_write = 1'b1; din = 16'(i);
      tick();
      chk("fill_count", count, i);
      chk("fill_full", full, (i == 8));
      chk("fill_empty", empty, 0);
    end
    din = 16'd9;
    tick();
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count, 8);
    chk("ovf_full", full, 1);
    FIFO_write = 1'b0;
    tick();
    chk("ovf_clear", overflow, 0);

    // Drain 1..8
    for (int i = 1; i <= 8; i++) begin
      FIFO_read = 1'b1;
      tick();
      chk("drain_dout", dout, i);
      chk("drain_valid", valid_out, 1);
      chk("drain_count", count, 8 - i);
      chk("drain_empty", empty, (i == 8));
    end
    tick();
    chk("unf_pulse", underflow, 1);
    chk("unf_valid", valid_out, 0);
    chk("unf_dout_hold", dout, 8);
    FIFO_read = 1'b0;
    tick();
    chk("unf_clear", underflow, 0);

    // Full plus simultaneous read/write
    for (int i = 1; i <= 8; i++) begin
      FIFO_write = 1'b1; din = 16'(i);
      tick();
    end
    chk("refill_full", full, 1);
    FIFO_write = 1'b1; FIFO_read = 1'b1; din = 16'd9;
    tick();
    chk("rw_full_dout", dout, 1);
    chk("rw_full_valid", valid_out, 1);
    chk("rw_full_count", count, 8);
    chk("rw_full_full", full, 1);
    chk("rw_full_ovf", overflow, 0);
    FIFO_write = 1'b0;
    for (int i = 2; i <= 9; i++) begin
      tick();
      chk("rw_drain_dout", dout, i);
    end
    chk("rw_drain_empty", empty, 1);

    // Empty plus simultaneous read/write: no fall-through
    FIFO_write = 1'b1; FIFO_read = 1'b1; din = 16'h0055;
    tick();
    chk("rw_empty_unf", underflow, 1);
    chk("rw_empty_count", count, 1);
    chk("rw_empty_valid", valid_out, 0);
    chk("rw_empty_empty", empty, 0);
    FIFO_write = 1'b0;
    tick();
    chk("rw_empty_dout", dout, 16'h0055);
    chk("rw_empty_cnt0", count, 0);
    FIFO_read = 1'b0;
    tick();

    // Wrap-around streaming at occupancy 3
    for (int i = 0; i < 3; i++) begin
      FIFO_write = 1'b1; din = 16'(100 + i);
      tick();
    end
    chk("wrap_pre_count", count, 3);
    for (int k = 0; k < 20; k++) begin
      FIFO_write = 1'b1; FIFO_read = 1'b1; din = 16'(103 + k);
      tick();
      chk("wrap_dout", dout, 100 + k);
      chk("wrap_valid", valid_out, 1);
      chk("wrap_count", count, 3);
      chk("wrap_flags", {full, empty}, 2'b00);
    end
    FIFO_write = 1'b0;
    for (int i = 120; i <= 122; i++) begin
      tick();
      chk("wrap_tail_dout", dout, i);
    end
    FIFO_read = 1'b0;
    tick();
    chk("wrap_end_empty", empty, 1);

    // Async reset with 5 entries stored
    for (int i = 1; i <= 5; i++) begin
      FIFO_write = 1'b1; din = 16'(i);
      tick();
    end
    FIFO_write = 1'b0;
    tick();
    chk("mid_pre_count", count, 5);
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_full", full, 0);
    #2 RST = 1'b1;
    tick();
    chk("post_rst_count", count, 0);
    FIFO_write = 1'b1; din = 16'hAAAA;
    tick();
    chk("post_wr_count", count, 1);
    FIFO_write = 1'b0; FIFO_read = 1'b1;
    tick();
    chk("post_rd_dout", dout, 16'hAAAA);
    chk("post_rd_valid", valid_out, 1);
    chk("post_rd_count", count, 0);
    FIFO_read = 1'b0;
    tick();
    chk("post_valid_low", valid_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
